// File: rtl/sha3_pkg.sv
// Shared constants for the SHA3-256 rate-block padder: geometry, padding bytes
// and FSM state encodings.
package sha3_pkg;

    localparam int RATE_BYTES = 136;
    localparam int WORD_BYTES = 8;
    localparam int NWORDS     = RATE_BYTES / WORD_BYTES;

    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
    localparam logic [7:0] PAD_END     = 8'h80;

    localparam logic [1:0] ACCEPT = 2'd0;
    localparam logic [1:0] EMIT   = 2'd1;
    localparam logic [1:0] EXTRA  = 2'd2;

endpackage

// File: rtl/sha3_pad_word.sv
// Masks one message word down to its first nbytes bytes and optionally drops
// the domain byte into the first unused byte position.
module sha3_pad_word
    import sha3_pkg::*;
(
    input  logic [63:0] word,
    input  logic [3:0]  nbytes,
    input  logic        insert,
    output logic [63:0] padded
);

    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
            localparam logic [3:0] IDX = 4'(gi);
            assign padded[8*gi +: 8] = (IDX < nbytes)               ? word[8*gi +: 8] :
                                       (insert && (IDX == nbytes))  ? DOMAIN_BYTE     :
                                                                      8'h00;
        end
    endgenerate

endmodule

// File: rtl/sha3_pad_blocker.sv
// Packs a 64-bit message stream into 1088-bit SHA3 rate blocks, applies the
// 0x06..0x80 multi-rate padding and hands blocks downstream over valid/ready.
module sha3_pad_blocker
    import sha3_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_nbytes,
    output logic [1087:0] block_out,
    output logic          block_valid,
    input  logic          block_ready,
    output logic          block_last
);

    logic [1:0]  state_reg;
    logic [4:0]  wcnt_reg;
    logic        pad_pending_reg;
    logic        last_reg;

    logic [3:0]  n_clamp;
    logic [3:0]  n_word;
    logic        full_tail;
    logic        pad_now;
    logic        take;
    logic        load_extra;
    logic [63:0] word_padded;

    assign n_clamp    = (in_nbytes > 4'd8) ? 4'd8 : in_nbytes;
    assign full_tail  = (wcnt_reg == 5'(NWORDS - 1)) && (n_clamp == 4'd8);
    // A full final word filling the last slot leaves no room: padding spills
    // into a separate pad-only block.
    assign pad_now    = in_last && !full_tail;
    assign take       = (state_reg == ACCEPT) && in_valid;
    assign load_extra = (state_reg == EMIT) && block_ready && pad_pending_reg;
    assign n_word     = in_last ? n_clamp : 4'd8;

    sha3_pad_word u_pad_word (
        .word   (in_data),
        .nbytes (n_word),
        .insert (pad_now),
        .padded (word_padded)
    );

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_slot
            localparam logic [4:0] SLOT = 5'(gi);
            logic [63:0] slot_reg;
            logic [63:0] slot_next;

            always_comb begin
                slot_next = slot_reg;
                if (take) begin
                    if (wcnt_reg == SLOT) begin
                        slot_next = word_padded;
                    end else if (in_last && (SLOT > wcnt_reg)) begin
                        // A full last word pushes the domain byte into the next slot.
                        if (pad_now && (n_clamp == 4'd8) && (SLOT == wcnt_reg + 5'd1)) begin
                            slot_next = {56'd0, DOMAIN_BYTE};
                        end else begin
                            slot_next = '0;
                        end
                    end
                    if (pad_now && (gi == NWORDS - 1)) begin
                        slot_next[63:56] = slot_next[63:56] | PAD_END;
                    end
                end else if (load_extra) begin
                    slot_next = '0;
                    if (gi == 0) begin
                        slot_next[7:0] = DOMAIN_BYTE;
                    end
                    if (gi == NWORDS - 1) begin
                        slot_next[63:56] = PAD_END;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= slot_next;
                end
            end

            assign block_out[64*gi +: 64] = slot_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ACCEPT;
            wcnt_reg        <= '0;
            pad_pending_reg <= 1'b0;
            last_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ACCEPT: begin
                    if (in_valid) begin
                        if (in_last || (wcnt_reg == 5'(NWORDS - 1))) begin
                            state_reg       <= EMIT;
                            wcnt_reg        <= '0;
                            last_reg        <= pad_now;
                            pad_pending_reg <= in_last && !pad_now;
                        end else begin
                            wcnt_reg <= wcnt_reg + 5'd1;
                        end
                    end
                end
                EMIT: begin
                    if (block_ready) begin
                        if (pad_pending_reg) begin
                            state_reg       <= EXTRA;
                            last_reg        <= 1'b1;
                            pad_pending_reg <= 1'b0;
                        end else begin
                            state_reg <= ACCEPT;
                            last_reg  <= 1'b0;
                            wcnt_reg  <= '0;
                        end
                    end
                end
                EXTRA: begin
                    if (block_ready) begin
                        state_reg <= ACCEPT;
                        last_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ACCEPT;
                end
            endcase
        end
    end

    assign in_ready    = (state_reg == ACCEPT) && !reset;
    assign block_valid = (state_reg == EMIT) || (state_reg == EXTRA);
    assign block_last  = last_reg;

endmodule

// File: tb/tb_sha3_pad_blocker.sv
// Scoreboard bench for sha3_pad_blocker: a byte-level SHA3 padding model
// queues expected blocks; a monitor compares every cycle a block is offered.
module tb_sha3_pad_blocker;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_nbytes;
    logic [1087:0] block_out;
    logic          block_valid;
    logic          block_ready;
    logic          block_last;

    always #5 clk = ~clk;

    sha3_pad_blocker dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_nbytes   (in_nbytes),
        .block_out   (block_out),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_last  (block_last)
    );

    typedef struct {
        logic [1087:0] data;
        logic          last;
        logic          follow_on;
    } blk_t;

    blk_t        exp_q[$];
    byte unsigned msg_buf[512];
    int          checks   = 0;
    int          failures = 0;
    int          bp_delay = 0;

    task automatic check_val(input string tag, input logic [1087:0] obs, input logic [1087:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: compare offered block against the queue head every cycle,
    // apply backpressure, and check the cycle after each handshake.
    initial begin
        int   vcnt;
        bit   post_check;
        bit   post_follow;
        blk_t front;
        vcnt        = 0;
        post_check  = 0;
        post_follow = 0;
        block_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                vcnt        = 0;
                post_check  = 0;
                block_ready = 1'b0;
                continue;
            end
            if (post_check) begin
                check_val("after_hs_in_ready", in_ready, !post_follow);
                check_val("after_hs_valid", block_valid, post_follow);
                post_check = 0;
            end
            if (block_valid) begin
                check_val("in_ready_while_valid", in_ready, 0);
                if (exp_q.size() == 0) begin
                    check_val("unexpected_block", block_valid, 0);
                    block_ready = 1'b1;
                end else begin
                    front = exp_q[0];
                    check_val("block_out", block_out, front.data);
                    check_val("block_last", block_last, front.last);
                    vcnt++;
                    if (vcnt > bp_delay) begin
                        block_ready = 1'b1;
                        void'(exp_q.pop_front());
                        post_check  = 1;
                        post_follow = front.follow_on;
                        vcnt        = 0;
                    end else begin
                        block_ready = 1'b0;
                    end
                end
            end else begin
                block_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic accept_word();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 300) begin
                check_val("in_ready_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input int len, input bit junk_ff);
        int           nw;
        int           n;
        int           nblk;
        byte unsigned pb[];
        logic [63:0]  w;
        int           idx;
        blk_t         e;
        nblk = len / 136 + 1;
        pb   = new[nblk * 136];
        for (int i = 0; i < nblk * 136; i++) pb[i] = (i < len) ? msg_buf[i] : 8'h00;
        pb[len]            = pb[len] | 8'h06;
        pb[nblk * 136 - 1] = pb[nblk * 136 - 1] | 8'h80;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int k = 0; k < 136; k++) e.data[8*k +: 8] = pb[b*136 + k];
            e.last      = (b == nblk - 1);
            e.follow_on = ((len % 136) == 0) && (b == nblk - 2);
            exp_q.push_back(e);
        end
        nw = (len == 0) ? 1 : (len + 7) / 8;
        n  = len - 8 * (nw - 1);
        for (int wi = 0; wi < nw; wi++) begin
            for (int j = 0; j < 8; j++) begin
                idx = 8 * wi + j;
                w[8*j +: 8] = (idx < len) ? msg_buf[idx] : (junk_ff ? 8'hFF : 8'($urandom));
            end
            in_data  = w;
            in_valid = 1'b1;
            if (wi == nw - 1) begin
                in_last = 1'b1;
                if (n == 8 && $urandom_range(0, 1) == 1) in_nbytes = 4'(8 + $urandom_range(1, 7));
                else in_nbytes = 4'(n);
            end else begin
                in_last   = 1'b0;
                in_nbytes = 4'($urandom_range(0, 15));
            end
            accept_word();
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 || block_valid) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                check_val("drain_timeout", exp_q.size(), 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) msg_buf[i] = 8'($urandom);
    endtask

    initial begin
        int lens[7];
        lens = '{1, 7, 8, 137, 200, 271, 272};
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_nbytes = '0;
        @(negedge clk);
        check_val("reset_cycle_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("post_reset_in_ready", in_ready, 1);
        check_val("post_reset_valid", block_valid, 0);
        check_val("post_reset_last", block_last, 0);
        check_val("post_reset_block_out", block_out, 0);
        @(posedge clk);
        #1;

        $display("msg empty");
        send_msg(0, 0);
        wait_drain();

        $display("msg abc");
        msg_buf[0] = 8'h61;
        msg_buf[1] = 8'h62;
        msg_buf[2] = 8'h63;
        send_msg(3, 1);
        wait_drain();

        $display("msg 135 bytes with backpressure");
        bp_delay = 5;
        fill_random(135);
        send_msg(135, 0);
        wait_drain();
        bp_delay = 0;

        $display("msg 136 bytes");
        fill_random(136);
        send_msg(136, 0);
        wait_drain();

        $display("reset after 9 words");
        for (int wi = 0; wi < 9; wi++) begin
            in_data   = {$urandom, $urandom};
            in_last   = 1'b0;
            in_nbytes = 4'd8;
            in_valid  = 1'b1;
            accept_word();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_val("mid_reset_in_ready", in_ready, 0);
        check_val("mid_reset_valid", block_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("after_mid_reset_in_ready", in_ready, 1);
        check_val("after_mid_reset_valid", block_valid, 0);
        @(posedge clk);
        #1;
        send_msg(0, 0);
        wait_drain();

        foreach (lens[i]) begin
            bp_delay = $urandom_range(0, 2);
            $display("msg %0d bytes bp=%0d", lens[i], bp_delay);
            fill_random(lens[i]);
            send_msg(lens[i], 0);
            wait_drain();
        end

        repeat (5) @(negedge clk);
        check_val("final_valid", block_valid, 0);
        check_val("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
